calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter: ILLEGAL_OP_ERR, 1, when 1 opcodes 3'b101-3'b111 set out_err; when 0 they execute as add.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  command present.
REQ-005 SHALL have port: in_ready  output  1  command accepted when in_valid & in_ready at a clk edge.
REQ-006 SHALL have port: in_a  input  3  operand A, sign-magnitude (bit2 sign, bits1:0 magnitude).
REQ-007 SHALL have port: in_b  input  3  operand B, same format.
REQ-008 SHALL have port: in_op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 rem.
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-011 SHALL have port: out_result  output  5  sign-magnitude result (bit4 sign, bits3:0 magnitude).
REQ-012 SHALL have port: out_err  output  1  divide-by-zero or illegal opcode, valid with out_valid.
REQ-013 SHALL have port: busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; in_a/in_b/in_op captured only at acceptance.
REQ-015 SHALL assert in_ready only in IDLE (macro off).
REQ-016 SHALL use one EXEC cycle for add/sub, two EXEC cycles for mul (shift-add, one magnitude bit per step) and div/rem (restoring, one quotient bit per step), with a 2-bit step counter.
REQ-017 SHALL raise out_valid at edge k+2 after acceptance edge k for add/sub and at k+3 for mul/div/rem.
REQ-018 SHALL, for div/rem with |b|=0 or illegal opcode (ILLEGAL_OP_ERR=1), skip EXEC, go directly to DONE (out_valid at k+1), out_result=0, out_err=1.
REQ-019 SHALL compute add/sub on signed values (range -6..+6), mul magnitude |a|*|b| (max 9) with sign sa^sb, div quotient truncated toward zero with sign sa^sb, rem = |a| mod |b| with sign sa.
REQ-020 SHALL treat negative-zero operands as zero and always output zero results with sign bit 0.
REQ-021 SHALL hold out_result/out_err stable while out_valid & !out_ready; DONE exits only on out_valid & out_ready.
REQ-022 SHALL drive out_result=0, out_err=0 whenever out_valid=0.

Reset
REQ-023 SHALL on rst force state IDLE, step counter 0, out_valid 0, out_result 0, out_err 0, busy 0, in_ready 1, independent of clk.
REQ-024 SHALL abandon any in-flight command (and buffered command) on rst with no result emitted.

Configuration
REQ-025 SHALL support macro CALC_CMDBUF_EN; undefined: no buffering, in_ready = (state==IDLE).
REQ-026 SHALL with CALC_CMDBUF_EN add one-entry command buffer; in_ready = (state==IDLE) | buffer empty; commands accepted outside IDLE go to buffer.
REQ-027 SHALL with CALC_CMDBUF_EN, on DONE exit with buffer full, enter EXEC (or DONE for error cases) with buffered command on the same edge; buffer write and DONE exit on the same edge -> go IDLE, launch buffered command next edge.
REQ-028 SHALL with CALC_CMDBUF_EN treat IDLE with buffer full as immediate launch, buffer taking priority over in_valid (in_ready stays high only if buffer drains that edge).

Verification
REQ-029 SHALL cover: add a=011 (+3), b=110 (-2) -> out_result=00001, out_err=0, out_valid at k+2.
REQ-030 SHALL cover: mul a=111 (-3), b=011 (+3) -> 11001 (-9) at k+3; div a=111, b=010 -> 10001; rem a=111, b=010 -> 10001.
REQ-031 SHALL cover: div a=010, b=100 (-0) -> out_err=1, out_result=00000, out_valid at k+1; op=110 -> out_err=1.
REQ-032 SHALL cover: out_ready low 5 cycles after result -> out_result stable, busy=1, in_ready=0 (macro off).
REQ-033 SHALL cover: rst pulse during second mul EXEC cycle -> all outputs reset values immediately; next add 001+001 -> 00010.
REQ-034 SHALL cover (CALC_CMDBUF_EN): second command sub 000-001 accepted during EXEC -> results back-to-back, second = 10001, no IDLE gap.

Source files
------------

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - sign-magnitude calculator command controller (IDLE/EXEC/DONE)
// Optional one-entry command buffer enabled by defining CALC_CMDBUF_EN.
module calc_ctrl #(
    parameter int ILLEGAL_OP_ERR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    input  logic [2:0] in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_result,
    output logic       out_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;

    state_t     state;
    logic [1:0] step;
    logic [2:0] a_r, b_r, op_r;
    logic [3:0] acc;
    logic [1:0] rem_r;
    logic       res_neg;
    logic [3:0] res_mag;
    logic       res_err;

    logic       l_go, l_err, done_exit;
    logic [2:0] l_a, l_b, l_op;
    logic [2:0] eff_op;
    logic [3:0] ua, ub, va, vb, sum, as_mag, pp, mul_n, quo_n;
    logic [2:0] trial;
    logic       ge;
    logic [1:0] rem_n;

`ifdef CALC_CMDBUF_EN
    logic       buf_full, buf_wr, buf_rd;
    logic [2:0] buf_a, buf_b, buf_op;

    assign in_ready = (state == IDLE) | ~buf_full;
`else
    assign in_ready = (state == IDLE);
`endif

    assign busy      = (state != IDLE);
    assign done_exit = (state == DONE) & out_valid & out_ready;

    // Pick the command to launch this edge; a buffered command outranks a new one.
    always_comb begin
        l_a  = in_a;
        l_b  = in_b;
        l_op = in_op;
        l_go = 1'b0;
`ifdef CALC_CMDBUF_EN
        buf_rd = 1'b0;
        if (((state == IDLE) | done_exit) & buf_full) begin
            l_go   = 1'b1;
            l_a    = buf_a;
            l_b    = buf_b;
            l_op   = buf_op;
            buf_rd = 1'b1;
        end else if (state == IDLE) begin
            l_go = in_valid;
        end
        buf_wr = in_valid & in_ready & ~((state == IDLE) & ~buf_full);
`else
        l_go = (state == IDLE) & in_valid;
`endif
    end

    assign l_err = (((l_op == OP_DIV) || (l_op == OP_REM)) && (l_b[1:0] == 2'b00)) ||
                   ((ILLEGAL_OP_ERR != 0) && (l_op > OP_REM));

    assign eff_op = (op_r > OP_REM) ? OP_ADD : op_r;

    // Signed add/sub in 4-bit two's complement, then back to sign-magnitude.
    assign ua     = {2'b00, a_r[1:0]};
    assign ub     = {2'b00, b_r[1:0]};
    assign va     = a_r[2] ? (4'd0 - ua) : ua;
    assign vb     = b_r[2] ? (4'd0 - ub) : ub;
    assign sum    = (eff_op == OP_SUB) ? (va - vb) : (va + vb);
    assign as_mag = sum[3] ? (4'd0 - sum) : sum;

    // One multiplier bit per step (LSB first), one quotient bit per step (MSB first).
    assign pp    = b_r[step[0]] ? (ua << step[0]) : 4'd0;
    assign mul_n = acc + pp;
    assign trial = {rem_r, (step[0] ? a_r[0] : a_r[1])};
    assign ge    = (trial >= {1'b0, b_r[1:0]});
    assign rem_n = ge ? 2'(trial - {1'b0, b_r[1:0]}) : trial[1:0];
    assign quo_n = {acc[2:0], ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step       <= 2'd0;
            a_r        <= 3'd0;
            b_r        <= 3'd0;
            op_r       <= 3'd0;
            acc        <= 4'd0;
            rem_r      <= 2'd0;
            res_neg    <= 1'b0;
            res_mag    <= 4'd0;
            res_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= 5'd0;
            out_err    <= 1'b0;
`ifdef CALC_CMDBUF_EN
            buf_full   <= 1'b0;
            buf_a      <= 3'd0;
            buf_b      <= 3'd0;
            buf_op     <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    acc   <= (eff_op == OP_MUL) ? mul_n : quo_n;
                    rem_r <= rem_n;
                    step  <= step + 2'd1;
                    if ((eff_op == OP_ADD) || (eff_op == OP_SUB) || (step == 2'd1)) begin
                        state <= DONE;
                        step  <= 2'd0;
                        case (eff_op)
                            OP_MUL: begin
                                res_mag <= mul_n;
                                res_neg <= (a_r[2] ^ b_r[2]) & (|mul_n);
                            end
                            OP_DIV: begin
                                res_mag <= quo_n;
                                res_neg <= (a_r[2] ^ b_r[2]) & (|quo_n);
                            end
                            OP_REM: begin
                                res_mag <= {2'b00, rem_n};
                                res_neg <= a_r[2] & (|rem_n);
                            end
                            default: begin
                                res_mag <= as_mag;
                                res_neg <= sum[3];
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_result <= {res_neg, res_mag};
                        out_err    <= res_err;
                    end else if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_result <= 5'd0;
                        out_err    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Launch overrides the DONE->IDLE exit when a command is waiting.
            if (l_go) begin
                a_r     <= l_a;
                b_r     <= l_b;
                op_r    <= l_op;
                step    <= 2'd0;
                acc     <= 4'd0;
                rem_r   <= 2'd0;
                res_neg <= 1'b0;
                res_mag <= 4'd0;
                res_err <= l_err;
                state   <= l_err ? DONE : EXEC;
            end

`ifdef CALC_CMDBUF_EN
            if (buf_wr) begin
                buf_full <= 1'b1;
                buf_a    <= in_a;
                buf_b    <= in_b;
                buf_op   <= in_op;
            end else if (buf_rd) begin
                buf_full <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - self-checking bench for calc_ctrl (vector table, random vs model, corner sequences)
module tb_calc_ctrl;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [2:0] in_a, in_b, in_op;
    logic [4:0] out_result;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    calc_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_err(out_err), .busy(busy)
    );

    typedef struct {
        logic [2:0] a, b, op;
        logic [4:0] res;
        logic       err;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                                  output logic [4:0] res, output logic err, output int lat);
        int ma, mb, r;
        bit sa, sb;
        ma = int'(a[1:0]); mb = int'(b[1:0]); sa = a[2]; sb = b[2];
        err = 1'b0; r = 0;
        case (op)
            3'd0: r = (sa ? -ma : ma) + (sb ? -mb : mb);
            3'd1: r = (sa ? -ma : ma) - (sb ? -mb : mb);
            3'd2: r = (sa ^ sb) ? -(ma * mb) : ma * mb;
            3'd3: if (mb == 0) err = 1'b1; else r = (sa ^ sb) ? -(ma / mb) : ma / mb;
            3'd4: if (mb == 0) err = 1'b1; else r = sa ? -(ma % mb) : ma % mb;
            default: err = 1'b1;
        endcase
        res = {(r < 0), 4'(r < 0 ? -r : r)};
        lat = err ? 1 : ((op <= 3'd1) ? 2 : 3);
    endfunction

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
        int guard = 0;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 3'($urandom); in_b = 3'($urandom); in_op = 3'($urandom);
    endtask

    task automatic run_cmd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                           output logic [4:0] res, output logic err, output int lat);
        logic bad = 1'b0;
        issue(a, b, op);
        lat = 0;
        while (!out_valid && lat < 10) begin
            if (out_result != 5'd0 || out_err != 1'b0) bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        res = out_result; err = out_err;
        check("zero_while_invalid", 32'(bad), 32'd0);
        if (out_valid) begin @(posedge clk); #1; end
    endtask

    vec_t       vecs [14];
    logic [4:0] r, er, held;
    logic       e, ee, bad;
    int         l, el, n;
    logic [4:0] got [2];
    logic       exp_ready;

    initial begin
`ifdef CALC_CMDBUF_EN
        exp_ready = 1'b1;
`else
        exp_ready = 1'b0;
`endif
        vecs[0]  = '{3'b011, 3'b110, 3'b000, 5'b00001, 1'b0, 2};
        vecs[1]  = '{3'b111, 3'b011, 3'b010, 5'b11001, 1'b0, 3};
        vecs[2]  = '{3'b111, 3'b010, 3'b011, 5'b10001, 1'b0, 3};
        vecs[3]  = '{3'b111, 3'b010, 3'b100, 5'b10001, 1'b0, 3};
        vecs[4]  = '{3'b010, 3'b100, 3'b011, 5'b00000, 1'b1, 1};
        vecs[5]  = '{3'b001, 3'b001, 3'b110, 5'b00000, 1'b1, 1};
        vecs[6]  = '{3'b000, 3'b001, 3'b001, 5'b10001, 1'b0, 2};
        vecs[7]  = '{3'b100, 3'b100, 3'b000, 5'b00000, 1'b0, 2};
        vecs[8]  = '{3'b011, 3'b011, 3'b010, 5'b01001, 1'b0, 3};
        vecs[9]  = '{3'b011, 3'b110, 3'b100, 5'b00001, 1'b0, 3};
        vecs[10] = '{3'b101, 3'b011, 3'b011, 5'b00000, 1'b0, 3};
        vecs[11] = '{3'b110, 3'b011, 3'b001, 5'b10101, 1'b0, 2};
        vecs[12] = '{3'b001, 3'b000, 3'b100, 5'b00000, 1'b1, 1};
        vecs[13] = '{3'b100, 3'b111, 3'b010, 5'b00000, 1'b0, 3};

        rst = 1'b1; in_valid = 1'b0; in_a = 3'd0; in_b = 3'd0; in_op = 3'd0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1; rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, r, e, l);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            check($sformatf("vec%0d_latency", i), 32'(l), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0] ra, rb, rop;
            ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7)); rop = 3'($urandom_range(0, 7));
            model(ra, rb, rop, er, ee, el);
            run_cmd(ra, rb, rop, r, e, l);
            check($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
            check($sformatf("rnd%0d_err", i), 32'(e), 32'(ee));
            check($sformatf("rnd%0d_latency", i), 32'(l), 32'(el));
        end

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        issue(3'b111, 3'b011, 3'b010);
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("hold_latency", 32'(n), 32'd3);
        held = out_result;
        check("hold_first", 32'(held), 32'(5'b11001));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_result", i), 32'(out_result), 32'(5'b11001));
            check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_busy", i), 32'(busy), 32'd1);
            check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'(exp_ready));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release", 32'(out_valid), 32'd0);

        // Reset in the second mul EXEC cycle drops the command.
        issue(3'b011, 3'b011, 3'b010);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_result", 32'(out_result), 32'd0);
        check("mid_rst_out_err", 32'(out_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #2; rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad = 1'b1;
        end
        check("mid_rst_no_result", 32'(bad), 32'd0);
        run_cmd(3'b001, 3'b001, 3'b000, r, e, l);
        check("post_rst_result", 32'(r), 32'(5'b00010));
        check("post_rst_latency", 32'(l), 32'd2);

`ifdef CALC_CMDBUF_EN
        issue(3'b011, 3'b011, 3'b010);
        in_a = 3'b000; in_b = 3'b001; in_op = 3'b001; in_valid = 1'b1;
        check("buf_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; bad = 1'b0;
        for (int i = 0; i < 15 && n < 2; i++) begin
            if (out_valid) begin got[n] = out_result; n++; end
            else if (!busy) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("buf_count", 32'(n), 32'd2);
        check("buf_first", 32'(got[0]), 32'(5'b01001));
        check("buf_second", 32'(got[1]), 32'(5'b10001));
        check("buf_no_idle_gap", 32'(bad), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
